// File: rtl/blk_addr_composer.sv
// rtl/blk_addr_composer.sv - rebuilds block addresses from tag/index/offset and issues a critical-word-first wrap burst
module blk_addr_composer #(
   parameter int ADDR_WID   = 32,
   parameter int INDEX_MSB  = 9,
   parameter int INDEX_LSB  = 2,
   parameter int OFFSET_MSB = 1,
   parameter int OFFSET_LSB = 0,
   parameter int TAG_MSB    = 31,
   parameter int TAG_LSB    = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_rd,
   input  logic                         req_wr,
   input  logic [TAG_MSB:TAG_LSB]       req_tag,
   input  logic [INDEX_MSB:INDEX_LSB]   req_index,
   input  logic [OFFSET_MSB:OFFSET_LSB] req_offset,
   output logic                         bus_valid,
   input  logic                         bus_ready,
   output logic                         bus_rd,
   output logic                         bus_wr,
   output logic [ADDR_WID-1:0]          bus_addr,
   output logic                         bus_last,
   output logic [OFFSET_MSB:OFFSET_LSB] beat_offset,
   output logic                         done
);

   localparam int OW = OFFSET_MSB - OFFSET_LSB + 1;
   // Beats remaining after the first one: NBEATS-1 is all ones in OW bits.
   localparam logic [OW-1:0] REM_INIT = '1;
   localparam logic [OW-1:0] ONE      = OW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [TAG_MSB:TAG_LSB]     tag_q, tag_d;
   logic [INDEX_MSB:INDEX_LSB] index_q, index_d;
   logic [OW-1:0]              beat_q, beat_d;
   logic [OW-1:0]              rem_q, rem_d;
   logic                       rd_q, rd_d;
   logic                       wr_q, wr_d;

   // State and latched request fields; reset also clears the latched fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tag_q   <= '0;
         index_q <= '0;
         beat_q  <= '0;
         rem_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         index_q <= index_d;
         beat_q  <= beat_d;
         rem_q   <= rem_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   // Next state: accept only a single-command request, then walk the wrap order one beat per handshake.
   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      index_d = index_q;
      beat_d  = beat_q;
      rem_d   = rem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && (req_rd ^ req_wr)) begin
               state_d = S_ISSUE;
               tag_d   = req_tag;
               index_d = req_index;
               beat_d  = req_offset;
               rem_d   = REM_INIT;
               rd_d    = req_rd;
               wr_d    = req_wr;
            end
         end
         S_ISSUE: begin
            if (bus_ready) begin
               if (rem_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  beat_d = beat_q + ONE;
                  rem_d  = rem_q - ONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs: everything on the bus side is zero outside ISSUE, so stale fields never leak.
   always_comb begin
      req_ready   = (state_q == S_IDLE);
      done        = (state_q == S_DONE);
      bus_valid   = 1'b0;
      bus_rd      = 1'b0;
      bus_wr      = 1'b0;
      bus_last    = 1'b0;
      bus_addr    = '0;
      beat_offset = '0;
      if (state_q == S_ISSUE) begin
         bus_valid                       = 1'b1;
         bus_rd                          = rd_q;
         bus_wr                          = wr_q;
         bus_last                        = (rem_q == '0);
         beat_offset                     = beat_q;
         bus_addr[TAG_MSB:TAG_LSB]       = tag_q;
         bus_addr[INDEX_MSB:INDEX_LSB]   = index_q;
         bus_addr[OFFSET_MSB:OFFSET_LSB] = beat_q;
      end
   end

endmodule

// File: tb/tb_blk_addr_composer.sv
// tb/tb_blk_addr_composer.sv - randomized and directed bench for blk_addr_composer against a beat-queue model
module tb_blk_addr_composer;

   localparam int TAG_LSB_T   = 10;
   localparam int INDEX_LSB_T = 2;
   localparam int NB          = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_rd, req_wr;
   logic [21:0] req_tag;
   logic [7:0]  req_index;
   logic [1:0]  req_offset;
   logic        bus_valid, bus_ready, bus_rd, bus_wr, bus_last, done;
   logic [31:0] bus_addr;
   logic [1:0]  beat_offset;

   blk_addr_composer dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rd      (req_rd),
      .req_wr      (req_wr),
      .req_tag     (req_tag),
      .req_index   (req_index),
      .req_offset  (req_offset),
      .bus_valid   (bus_valid),
      .bus_ready   (bus_ready),
      .bus_rd      (bus_rd),
      .bus_wr      (bus_wr),
      .bus_addr    (bus_addr),
      .bus_last    (bus_last),
      .beat_offset (beat_offset),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  off;
      logic        rd;
      logic        wr;
   } beat_t;

   beat_t       exq[$];
   bit          done_pend;
   int          n_chk, n_err;
   int          hs_cnt, v_cnt;
   logic [31:0] hs_addr[$];
   logic [1:0]  hs_off[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outs();
      bit busy;
      busy = (exq.size() > 0);
      chk("req_ready", 32'(req_ready), 32'(!busy && !done_pend));
      chk("bus_valid", 32'(bus_valid), 32'(busy));
      chk("done", 32'(done), 32'(done_pend));
      if (busy) begin
         chk("bus_addr", bus_addr, exq[0].addr);
         chk("beat_offset", 32'(beat_offset), 32'(exq[0].off));
         chk("bus_rd", 32'(bus_rd), 32'(exq[0].rd));
         chk("bus_wr", 32'(bus_wr), 32'(exq[0].wr));
         chk("bus_last", 32'(bus_last), 32'(exq.size() == 1));
      end else begin
         chk("idle_addr", bus_addr, 32'h0);
         chk("idle_beat_offset", 32'(beat_offset), 32'h0);
         chk("idle_rd_wr_last", {29'h0, bus_rd, bus_wr, bus_last}, 32'h0);
      end
   endtask

   // One clock: drive inputs at negedge, advance the model across the coming edge, check at next negedge.
   task automatic cyc(input logic r, input logic v, input logic rd, input logic wr,
                      input logic [21:0] t, input logic [7:0] ix, input logic [1:0] of,
                      input logic br);
      beat_t b;
      rst = r; req_valid = v; req_rd = rd; req_wr = wr;
      req_tag = t; req_index = ix; req_offset = of; bus_ready = br;
      if (!r && bus_valid) v_cnt++;
      if (!r && bus_valid && br) begin
         hs_cnt++;
         hs_addr.push_back(bus_addr);
         hs_off.push_back(beat_offset);
      end
      if (r) begin
         exq.delete();
         done_pend = 0;
      end else if (exq.size() > 0) begin
         if (br) begin
            void'(exq.pop_front());
            if (exq.size() == 0) done_pend = 1;
         end
      end else if (done_pend) begin
         done_pend = 0;
      end else if (v && (rd ^ wr)) begin
         for (int i = 0; i < NB; i++) begin
            b.off  = 2'((int'(of) + i) % NB);
            b.addr = (32'(t) << TAG_LSB_T) | (32'(ix) << INDEX_LSB_T) | 32'(b.off);
            b.rd   = rd;
            b.wr   = wr;
            exq.push_back(b);
         end
      end
      @(negedge clk);
      check_outs();
   endtask

   task automatic idle(input int n, input logic br);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0, 2'd0, br);
   endtask

   task automatic clr_log();
      hs_addr.delete();
      hs_off.delete();
      hs_cnt = 0;
      v_cnt  = 0;
   endtask

   logic [31:0] t1_exp[4];
   logic [1:0]  t2_exp[4];

   initial begin
      n_chk = 0; n_err = 0; done_pend = 0;
      rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
      req_tag = '0; req_index = '0; req_offset = '0; bus_ready = 1'b0;
      t1_exp = '{32'h000AAC54, 32'h000AAC55, 32'h000AAC56, 32'h000AAC57};
      t2_exp = '{2'd2, 2'd3, 2'd0, 2'd1};
      @(negedge clk);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0, 2'd0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 22'h3FF, 8'hFF, 2'd3, 1'b1);

      // Read burst without stalls
      clr_log();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 22'h2AB, 8'h15, 2'd0, 1'b1);
      idle(6, 1'b1);
      chk("t1_handshakes", hs_addr.size(), 4);
      for (int i = 0; i < 4 && i < hs_addr.size(); i++) chk("t1_addr_seq", hs_addr[i], t1_exp[i]);

      // Critical-word-first wrap on a writeback
      clr_log();
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 22'($urandom), 8'($urandom), 2'd2, 1'b1);
      idle(6, 1'b1);
      chk("t2_handshakes", hs_off.size(), 4);
      for (int i = 0; i < 4 && i < hs_off.size(); i++) chk("t2_wrap_order", 32'(hs_off[i]), 32'(t2_exp[i]));

      // Backpressure on beat 2, with a busy-time request that must be ignored
      clr_log();
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 22'h155, 8'h2A, 2'd1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0, 2'd0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 22'h3FFFFF, 8'hFF, 2'd3, 1'b0);
      idle(6, 1'b1);
      chk("t3_valid_cycles", v_cnt, 7);
      chk("t3_handshakes", hs_cnt, 4);

      // Illegal request (both commands) is dropped
      clr_log();
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 22'h1, 8'h1, 2'd1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 22'h1, 8'h1, 2'd1, 1'b1);
      idle(2, 1'b1);
      chk("t4_no_valid", v_cnt, 0);

      // Reset after the first beat handshake, then a fresh burst from offset 3
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 22'h0F0, 8'h3C, 2'd1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0, 2'd0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0, 2'd0, 1'b1);
      idle(2, 1'b1);
      clr_log();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 22'h0F0, 8'h3C, 2'd3, 1'b1);
      idle(6, 1'b1);
      chk("t5_restart_first_off", hs_off.size() > 0 ? 32'(hs_off[0]) : 32'hFFFF, 32'd3);

      // Back-to-back: second request held through DONE
      clr_log();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 22'h0AA, 8'h55, 2'd0, 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 22'h1234, 8'h07, 2'd0, 1'b1);
      idle(6, 1'b1);
      chk("t6_handshakes", hs_cnt, 8);
      chk("t6_second_first_addr", hs_addr.size() > 4 ? hs_addr[4] : 32'hDEADBEEF, 32'h0048D01C);

      // Randomized traffic, including resets, illegal requests and stalls
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
             1'($urandom), 1'($urandom), 22'($urandom), 8'($urandom), 2'($urandom),
             ($urandom_range(0, 9) < 7));
      end
      idle(8, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
